// File: rtl/counter_sched_pkg.sv
// Shared types, default sizes and the round-robin pick helper for counter_rr_sched.
package counter_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned NREQ_MAX  = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request scanning upward from ptr+1, wrapping at nreq.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                    input logic [IDX_W-1:0]    ptr,
                                    input int unsigned         nreq);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
      j = (32'(ptr) + k) % nreq;
      if (k <= nreq && !p.valid && req[IDX_W'(j)]) begin
        p.valid = 1'b1;
        p.idx   = IDX_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/counter4_core.sv
// Shared up-counter datapath; the scheduler owns clear, enable and terminal detect.
module counter4_core
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler granting one shared counter to NREQ requesters, one counting session at a time.
module counter_rr_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] term,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [NREQ-1:0]       done
);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr, ptr_nxt;
  logic [IDX_W-1:0]      gidx, gidx_nxt;
  logic [WIDTH-1:0]      term_lat, term_nxt;
  logic [WIDTH-1:0]      term_sel;
  logic [NREQ-1:0]       gnt_nxt, done_nxt;
  logic                  busy_nxt;
  logic                  clr, en;
  logic [NREQ_MAX-1:0]   req_ext;
  pick_t                 pick;

  always_comb begin
    req_ext = NREQ_MAX'(req);
    pick    = rr_pick(req_ext, ptr, NREQ);
  end

  // Terminal value of the arbitration winner, captured only at grant.
  always_comb begin
    term_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == pick.idx) term_sel = term[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NREQ - 1);
      gidx     <= '0;
      term_lat <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      term_lat <= term_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    term_nxt  = term_lat;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        clr     = 1'b1;
        gnt_nxt = '0;
        if (pick.valid) begin
          state_nxt = COUNT;
          ptr_nxt   = pick.idx;
          gidx_nxt  = pick.idx;
          term_nxt  = term_sel;
          gnt_nxt   = NREQ'(NREQ_MAX'(1) << pick.idx);
        end
      end
      COUNT: begin
        // Abort wins over terminal detect: losing req never yields done.
        if (!req_ext[gidx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          clr       = 1'b1;
        end else if (q == term_lat) begin
          state_nxt = DONE;
          gnt_nxt   = '0;
          done_nxt  = NREQ'(NREQ_MAX'(1) << gidx);
        end else begin
          en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        clr       = 1'b1;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  counter4_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .q    (q)
  );

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed plus randomized bench for counter_rr_sched against a session-level reference model.
module tb_counter_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] term;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [NREQ-1:0]       done;

  int checks = 0;
  int errors = 0;
  int last_w;
  logic [WIDTH-1:0] term_arr [NREQ];

  always #5 clk = ~clk;

  counter_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .term (term),
    .gnt  (gnt),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_term();
    for (int i = 0; i < NREQ; i++) term[i*WIDTH +: WIDTH] = term_arr[i];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [3:0] eq,
                           input logic eb, input logic [3:0] ed);
    chk({tag, "_gnt"},  32'(gnt),  32'(eg));
    chk({tag, "_q"},    32'(q),    32'(eq));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  // Next requester after the previous winner, wrapping around.
  function automatic int predict(input logic [3:0] r);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last_w + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One whole session from the IDLE cycle: expected trace is q = 0..T, then done, then idle.
  task automatic do_session(input logic [3:0] reqv, input int abort_q, input int chg_val);
    int w;
    int t;
    logic [3:0] oh;
    w = predict(reqv);
    if (w < 0) return;
    oh = 4'(1) << w;
    t = int'(term_arr[w]);
    req = reqv;
    drive_term();
    for (int k = 0; k <= t; k++) begin
      tick();
      check_out((k == 0) ? "grant" : "count", oh, 4'(k), 1'b1, 4'b0);
      if (abort_q == k) begin
        req[w] = 1'b0;
        tick();
        check_out("abort", 4'b0, 4'b0, 1'b0, 4'b0);
        last_w = w;
        return;
      end
      if (k == 0 && chg_val >= 0) begin
        term_arr[w] = 4'(chg_val);
        drive_term();
      end
    end
    tick();
    check_out("done", 4'b0, 4'(t), 1'b1, oh);
    tick();
    check_out("idle", 4'b0, 4'b0, 1'b0, 4'b0);
    last_w = w;
  endtask

  initial begin
    int w;
    int ab;
    int cv;
    logic [3:0] rv;

    // Reset with all requesting, all terminals 2: expect grants 0,1,2,3,0.
    reset = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < NREQ; i++) term_arr[i] = 4'd2;
    drive_term();
    tick();
    tick();
    check_out("reset", 4'b0, 4'b0, 1'b0, 4'b0);
    last_w = NREQ - 1;
    reset = 1'b1;
    for (int n = 0; n < 5; n++) do_session(4'b1111, -1, -1);

    // Zero terminal: single COUNT cycle.
    term_arr[2] = 4'd0;
    do_session(4'b0100, -1, -1);

    // Full-range terminal without wrap.
    term_arr[0] = 4'd15;
    do_session(4'b0001, -1, -1);

    // Abort at q=4, then requester 0 wins over 1.
    term_arr[1] = 4'd9;
    do_session(4'b0010, 4, -1);
    do_session(4'b0011, -1, -1);

    // Reset in the middle of a session at q=6.
    term_arr[0] = 4'd10;
    req = 4'b0001;
    drive_term();
    tick();
    check_out("rgrant", 4'b0001, 4'd0, 1'b1, 4'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_out("rcount", 4'b0001, 4'(k), 1'b1, 4'b0);
    end
    reset = 1'b0;
    tick();
    check_out("rst_mid", 4'b0, 4'b0, 1'b0, 4'b0);
    last_w = NREQ - 1;
    reset = 1'b1;
    do_session(4'b1000, -1, -1);
    do_session(4'b1111, -1, -1);

    // Terminal changed mid-session is ignored until the next grant.
    term_arr[0] = 4'd3;
    do_session(4'b0001, -1, 12);
    do_session(4'b0001, -1, -1);

    // Randomized sessions with occasional aborts and terminal changes.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) term_arr[i] = 4'($urandom_range(0, 15));
      rv = 4'($urandom_range(1, 15));
      w  = predict(rv);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(term_arr[w]))) : -1;
      cv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      do_session(rv, ab, cv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_rr_sched.md
# counter_rr_sched

Round-robin scheduler that shares one 4-bit up-counter among up to NREQ requesters. Each granted requester runs a counting session from 0 up to its own terminal value, then receives a one-cycle done pulse and releases the counter. The block sits between requesting control logic and the shared counter datapath, and owns all sequencing of that counter: clear, enable and terminal detect.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, counter width in bits

Ports:
- clk  in  1  single system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level; must be held for the whole session
- term  in  NREQ*WIDTH  per-requester terminal count; slice i = term[i*WIDTH +: WIDTH]; sampled only at grant
- gnt  out  NREQ  one-hot grant, held for the whole COUNT state
- q  out  WIDTH  shared counter value
- busy  out  1  high whenever the state is not IDLE
- done  out  NREQ  one-cycle pulse to the requester that completed

## Operation
- Reset (reset==0 at a clk edge) sets: state=IDLE, q=0, gnt=0, done=0, busy=0, rr pointer=NREQ-1. Requester 0 therefore has first priority after reset.
- States are IDLE, COUNT and DONE.
- IDLE
  - q=0, gnt=0.
  - If req!=0, pick the first set req starting at ptr+1, modulo NREQ.
  - Next edge: latch term_lat=term slice of the winner, set gnt to the winner, ptr=winner, q=0, state=COUNT.
- COUNT
  - If req[g] is low for the granted g: abort. Next edge goes to IDLE with q=0, gnt=0 and no done pulse. ptr stays at g.
  - Else if q==term_lat: next edge goes to DONE with gnt=0, done[g]=1, and q holding term_lat.
  - Else: q=q+1.
- DONE
  - done pulses for exactly one cycle.
  - Next edge goes to IDLE with q=0 and done=0.
- Width and arithmetic rules:
  - q never exceeds term_lat, so it never wraps.
  - term_lat=0 gives a single COUNT cycle.
  - term_lat=2^WIDTH-1 is legal.
- Changes to term during a session are ignored.
- A requester that deasserts req in DONE is not affected. A requester still asserting req after DONE re-enters arbitration with lowest priority.
- Reset asserted mid-session overrides everything: reset values apply at that edge and no done pulse is issued.

## Timing
- req seen at edge n with the block in IDLE:
  - gnt and busy are high from edge n+1, with q=0.
  - q=k after edge n+1+k.
  - DONE is entered at edge n+2+T (T=term_lat), with done high for that cycle.
  - IDLE is reached at edge n+3+T.
  - The earliest next grant is at edge n+4+T.
- A session occupies T+3 cycles from grant to the next grant.
- Abort latency: req[g] low at edge m in COUNT gives gnt=0 and q=0 after edge m+1.
- gnt and done are never high in the same cycle. done is at most one-hot.

## Structure
- Package counter_sched_pkg holds:
  - the state typedef (IDLE/COUNT/DONE)
  - the default WIDTH and NREQ constants
  - a function rr_pick(req, ptr) that returns the winner index and a valid flag
- Sub-module counter4_core(clk, reset, clr, en, q) is the shared counter datapath. The scheduler drives clr and en only; terminal compare lives in the scheduler.
- Expected RTL size is about 150–250 lines across both modules.

## Test plan
- Reset with req=4'b1111, then release reset. Required: gnt=0001 first. With all term=2, q runs 0,1,2; done=0001 pulses; the following grants go 0010, 0100, 1000, 0001.
- req=0100 only, term[2]=0. Required: gnt=0100 for 1 cycle with q=0, then done=0100 one cycle, then IDLE. Total 3 cycles from grant to IDLE.
- req=0001, term[0]=15. Required: q counts 0..15 with no wrap, done after q=15, and busy high for 17 cycles.
- req=0010, term[1]=9; drop req[1] when q=4. Required: next cycle gnt=0, q=0, done never asserted. Then raising req=0011 grants 0001 first, because ptr is 1.
- Assert reset while q=6 in a session. Required: at that edge q=0, gnt=0, busy=0, done=0. After release with req=1000 held, the grant order restarts from requester 0 and gnt=1000 is issued.
- Change term[0] from 3 to 12 in the middle of a session. Required: the session ends at q=3. The next session for requester 0 ends at q=12.
